// File: rtl/audioplay_proce_cpu_mult_pkg.sv
// Shared types and helpers for the multiplier-cell sequencer: FSM states,
// operand widths and the partial-product recombination.
package audioplay_proce_cpu_mult_pkg;

  localparam int OP_W   = 32;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_COMBINE = 2'd2,
    ST_RESP    = 2'd3
  } mult_state_e;

  // Only the low halves of the cross products land inside the low 32 bits.
  function automatic logic [OP_W-1:0] mul_combine(
    input logic [OP_W-1:0] p1,
    input logic [OP_W-1:0] p2,
    input logic [OP_W-1:0] p3
  );
    return p1
         + {p2[HALF_W-1:0], {HALF_W{1'b0}}}
         + {p3[HALF_W-1:0], {HALF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/audioplay_proce_cpu_mult_arb.sv
// Two-way round-robin arbiter; a grant is also the accept, so the
// last-grant pointer moves whenever any grant is issued.
module audioplay_proce_cpu_mult_arb (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) begin
        grant = last_q ? 2'b01 : 2'b10;
      end else begin
        grant = valid;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant[1]) begin
      last_d = 1'b1;
    end else if (grant[0]) begin
      last_d = 1'b0;
    end
  end

  // Pointer starts as "req1 granted last" so req0 wins the first contest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/audioplay_proce_cpu_mult_ctrl.sv
// Sequencer for the 3-partial-product multiplier cell: arbitrates two
// requesters, runs one multiply at a time and returns the low 32 bits.
module audioplay_proce_cpu_mult_ctrl
  import audioplay_proce_cpu_mult_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_src1,
  input  logic [31:0]      req0_src2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_src1,
  input  logic [31:0]      req1_src2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_result,
  output logic [31:0]      mul_src1,
  output logic [31:0]      mul_src2,
  output logic             mul_en,
  input  logic [31:0]      mul_cell_p1,
  input  logic [31:0]      mul_cell_p2,
  input  logic [31:0]      mul_cell_p3
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mult_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  src1_q, src1_d;
  logic [OP_W-1:0]  src2_q, src2_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             id_q, id_d;
  logic [OP_W-1:0]  result_q, result_d;
  logic [1:0]       grant;
  logic             arb_enable;

  // Gating with reset_n keeps ready low while reset is held with requests pending.
  assign arb_enable = (state_q == ST_IDLE) && reset_n;

  audioplay_proce_cpu_mult_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   ({req1_valid, req0_valid}),
    .enable  (arb_enable),
    .grant   (grant)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    tag_d    = tag_q;
    id_d     = id_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          src1_d  = grant[1] ? req1_src1 : req0_src1;
          src2_d  = grant[1] ? req1_src2 : req0_src2;
          tag_d   = grant[1] ? req1_tag  : req0_tag;
          id_d    = grant[1];
          cnt_d   = CNT_LOAD;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cnt_q == '0) begin
          state_d = ST_COMBINE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_COMBINE: begin
        result_d = mul_combine(mul_cell_p1, mul_cell_p2, mul_cell_p3);
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      tag_q    <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      tag_q    <= tag_d;
      id_q     <= id_d;
      result_q <= result_d;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_tag    = tag_q;
  assign rsp_result = result_q;
  assign mul_src1   = src1_q;
  assign mul_src2   = src2_q;
  assign mul_en     = (state_q == ST_ISSUE);

endmodule

// File: tb/tb_audioplay_proce_cpu_mult_ctrl.sv
// Bench for the multiplier sequencer: two instances (LATENCY 1 and 3), each
// beside a behavioural cell, checked against plain (a*b) mod 2^32.
module tb_audioplay_proce_cpu_mult_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        r0v[2], r1v[2], r0rdy[2], r1rdy[2], rv[2], rr[2], rid[2], men[2];
  logic [31:0] r0a[2], r0b[2], r1a[2], r1b[2], rres[2], ms1[2], ms2[2];
  logic [31:0] p1[2], p2[2], p3[2];
  logic [3:0]  r0t[2], r1t[2], rtag[2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [31:0] s1[LAT], s2[LAT], s3[LAT];

    audioplay_proce_cpu_mult_ctrl #(.LATENCY(LAT), .TAG_W(4)) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req0_valid  (r0v[gi]),
      .req0_ready  (r0rdy[gi]),
      .req0_src1   (r0a[gi]),
      .req0_src2   (r0b[gi]),
      .req0_tag    (r0t[gi]),
      .req1_valid  (r1v[gi]),
      .req1_ready  (r1rdy[gi]),
      .req1_src1   (r1a[gi]),
      .req1_src2   (r1b[gi]),
      .req1_tag    (r1t[gi]),
      .rsp_valid   (rv[gi]),
      .rsp_ready   (rr[gi]),
      .rsp_id      (rid[gi]),
      .rsp_tag     (rtag[gi]),
      .rsp_result  (rres[gi]),
      .mul_src1    (ms1[gi]),
      .mul_src2    (ms2[gi]),
      .mul_en      (men[gi]),
      .mul_cell_p1 (p1[gi]),
      .mul_cell_p2 (p2[gi]),
      .mul_cell_p3 (p3[gi])
    );

    // Cell model: lo*lo, hi*lo, lo*hi partial products through LAT enabled stages.
    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k < LAT; k++) begin
          s1[k] <= '0;
          s2[k] <= '0;
          s3[k] <= '0;
        end
      end else if (men[gi]) begin
        s1[0] <= {16'h0, ms1[gi][15:0]}  * {16'h0, ms2[gi][15:0]};
        s2[0] <= {16'h0, ms1[gi][31:16]} * {16'h0, ms2[gi][15:0]};
        s3[0] <= {16'h0, ms1[gi][15:0]}  * {16'h0, ms2[gi][31:16]};
        for (int k = 1; k < LAT; k++) begin
          s1[k] <= s1[k-1];
          s2[k] <= s2[k-1];
          s3[k] <= s3[k-1];
        end
      end
    end

    assign p1[gi] = s1[LAT-1];
    assign p2[gi] = s2[LAT-1];
    assign p3[gi] = s3[LAT-1];
  end

  function automatic logic get_rdy(input bit d, input bit r);
    return r ? r1rdy[d] : r0rdy[d];
  endfunction

  task automatic set_req(input bit d, input bit r, input logic v,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    if (!r) begin
      r0v[d] = v; r0a[d] = a; r0b[d] = b; r0t[d] = t;
    end else begin
      r1v[d] = v; r1a[d] = a; r1b[d] = b; r1t[d] = t;
    end
  endtask

  task automatic clear_inputs;
    for (int i = 0; i < 2; i++) begin
      set_req(bit'(i), 1'b0, 1'b0, '0, '0, '0);
      set_req(bit'(i), 1'b1, 1'b0, '0, '0, '0);
      rr[i] = 1'b0;
    end
  endtask

  // Call just after a negedge with the request driven; returns at the negedge after the handshake.
  task automatic wait_accept(input bit d, input bit r, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (get_rdy(d, r)) begin
        ok = 1'b1;
        n  = cyc;
      end
      @(negedge clk);
    end
  endtask

  // Returns #1 after the negedge of the first cycle with rsp_valid high.
  task automatic wait_rsp(input bit d, output int rc, output int en, output bit ok);
    ok = 1'b0;
    en = 0;
    rc = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (rv[d]) begin
        ok = 1'b1;
        rc = cyc;
      end else begin
        if (men[d]) en++;
        @(negedge clk);
      end
    end
  endtask

  task automatic ack_rsp(input bit d);
    rr[d] = 1'b1;
    @(negedge clk);
    rr[d] = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(bit'(i), 1'b0, 1'b1, $urandom, $urandom, 4'($urandom));
      set_req(bit'(i), 1'b1, 1'b1, $urandom, $urandom, 4'($urandom));
      rr[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({r0rdy[i], r1rdy[i], rv[i], rid[i], men[i]} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctl d=%0d: got rdy0/rdy1/valid/id/en=%b%b%b%b%b want 00000",
                 i, r0rdy[i], r1rdy[i], rv[i], rid[i], men[i]);
      end
      checks++;
      if (rres[i] !== 32'h0 || rtag[i] !== 4'h0) begin
        errors++;
        $display("FAIL reset_rsp d=%0d: got result=%h tag=%h want 0/0", i, rres[i], rtag[i]);
      end
      checks++;
      if (ms1[i] !== 32'h0 || ms2[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_src d=%0d: got src1=%h src2=%h want 0/0", i, ms1[i], ms2[i]);
      end
    end
    clear_inputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single(input bit d, input bit r, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] t, input logic [31:0] exp_res);
    int n, rc, en, lat;
    bit ok;
    lat = d ? 3 : 1;
    @(negedge clk);
    set_req(d, r, 1'b1, a, b, t);
    wait_accept(d, r, n, ok);
    set_req(d, r, 1'b0, '0, '0, '0);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_accept d=%0d r=%0d: got no ready want ready", d, r);
    end
    wait_rsp(d, rc, en, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_rsp d=%0d: got no rsp_valid want rsp_valid", d);
    end
    checks++;
    if (rc - n != lat + 2) begin
      errors++;
      $display("FAIL single_latency d=%0d: got N+%0d want N+%0d", d, rc - n, lat + 2);
    end
    checks++;
    if (en != lat) begin
      errors++;
      $display("FAIL single_mul_en d=%0d: got %0d cycles want %0d", d, en, lat);
    end
    checks++;
    if (rres[d] !== exp_res) begin
      errors++;
      $display("FAIL single_result d=%0d: got %h want %h", d, rres[d], exp_res);
    end
    checks++;
    if (rid[d] !== r || rtag[d] !== t) begin
      errors++;
      $display("FAIL single_id_tag d=%0d: got id=%b tag=%h want id=%b tag=%h", d, rid[d], rtag[d], r, t);
    end
    ack_rsp(d);
    #1;
    checks++;
    if (rv[d] !== 1'b0) begin
      errors++;
      $display("FAIL single_done d=%0d: got rsp_valid=%b want 0", d, rv[d]);
    end
  endtask

  task automatic test_round_robin(input bit d);
    logic [31:0] a[2], b[2], ea;
    logic [3:0]  t[2], et;
    bit g, seen, ok;
    int rc, en;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      a[r] = $urandom; b[r] = $urandom; t[r] = 4'(r * 8);
      set_req(d, bit'(r), 1'b1, a[r], b[r], t[r]);
    end
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        #1;
        if (r0rdy[d] || r1rdy[d]) seen = 1'b1;
        else @(negedge clk);
      end
      g = r1rdy[d];
      checks++;
      if (!seen || (r0rdy[d] && r1rdy[d]) || int'(g) != (k % 2)) begin
        errors++;
        $display("FAIL rr_grant op=%0d: got ready0=%b ready1=%b want grant to %0d", k, r0rdy[d], r1rdy[d], k % 2);
      end
      ea = a[g] * b[g];
      et = t[g];
      @(negedge clk);
      a[g] = $urandom; b[g] = $urandom; t[g] = t[g] + 4'd1;
      set_req(d, g, 1'b1, a[g], b[g], t[g]);
      wait_rsp(d, rc, en, ok);
      checks++;
      if (!ok || rid[d] !== g || rtag[d] !== et || rres[d] !== ea) begin
        errors++;
        $display("FAIL rr_rsp op=%0d: got valid=%b id=%b tag=%h result=%h want 1/%b/%h/%h",
                 k, rv[d], rid[d], rtag[d], rres[d], g, et, ea);
      end
      ack_rsp(d);
    end
    set_req(d, 1'b0, 1'b0, '0, '0, '0);
    set_req(d, 1'b1, 1'b0, '0, '0, '0);
  endtask

  task automatic test_stall;
    logic [31:0] a0, b0, a1, b1, a2, b2, ea, eb, ec;
    int n, rc, en;
    bit ok;
    @(negedge clk);
    a0 = $urandom; b0 = $urandom; ea = a0 * b0;
    a1 = $urandom; b1 = $urandom; eb = a1 * b1;
    a2 = $urandom; b2 = $urandom; ec = a2 * b2;
    set_req(0, 0, 1'b1, a0, b0, 4'h6);
    wait_accept(0, 0, n, ok);
    set_req(0, 0, 1'b1, a1, b1, 4'h7);
    set_req(0, 1, 1'b1, a2, b2, 4'h8);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_accept: got no ready want ready");
    end
    wait_rsp(0, rc, en, ok);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rv[0], rid[0], rtag[0], rres[0], r0rdy[0], r1rdy[0]} !== {1'b1, 1'b0, 4'h6, ea, 2'b00}) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d: got valid=%b id=%b tag=%h result=%h rdy=%b%b want 1/0/6/%h/00",
                 i, rv[0], rid[0], rtag[0], rres[0], r0rdy[0], r1rdy[0], ea);
      end
      @(negedge clk);
      #1;
    end
    rr[0] = 1'b1;
    @(negedge clk);
    rr[0] = 1'b0;
    #1;
    checks++;
    if (rv[0] !== 1'b0 || r1rdy[0] !== 1'b1 || r0rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got valid=%b rdy0=%b rdy1=%b want 0/0/1", rv[0], r0rdy[0], r1rdy[0]);
    end
    @(negedge clk);
    set_req(0, 1, 1'b0, '0, '0, '0);
    wait_rsp(0, rc, en, ok);
    checks++;
    if (!ok || rid[0] !== 1'b1 || rtag[0] !== 4'h8 || rres[0] !== ec) begin
      errors++;
      $display("FAIL stall_next: got valid=%b id=%b tag=%h result=%h want 1/1/8/%h", rv[0], rid[0], rtag[0], rres[0], ec);
    end
    ack_rsp(0);
    wait_accept(0, 0, n, ok);
    set_req(0, 0, 1'b0, '0, '0, '0);
    wait_rsp(0, rc, en, ok);
    checks++;
    if (!ok || rid[0] !== 1'b0 || rtag[0] !== 4'h7 || rres[0] !== eb) begin
      errors++;
      $display("FAIL stall_last: got valid=%b id=%b tag=%h result=%h want 1/0/7/%h", rv[0], rid[0], rtag[0], rres[0], eb);
    end
    ack_rsp(0);
  endtask

  task automatic test_reset_mid;
    logic [31:0] a, b, e;
    int n, rc, en;
    bit ok;
    a = 32'h1234_5678; b = 32'h9abc_def0; e = a * b;
    @(negedge clk);
    set_req(1, 0, 1'b1, 32'h7, 32'h9, 4'h5);
    wait_accept(1, 0, n, ok);
    set_req(1, 0, 1'b1, a, b, 4'h2);
    set_req(1, 1, 1'b1, 32'h3, 32'h4, 4'h9);
    #1;
    checks++;
    if (!ok || men[1] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_issue: got accept=%b mul_en=%b want 1/1", ok, men[1]);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({r0rdy[1], r1rdy[1], rv[1], rid[1], men[1]} !== 5'b0 || rres[1] !== 32'h0 ||
        rtag[1] !== 4'h0 || ms1[1] !== 32'h0 || ms2[1] !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: got rdy=%b%b valid=%b id=%b en=%b result=%h tag=%h src=%h/%h want all 0",
               r0rdy[1], r1rdy[1], rv[1], rid[1], men[1], rres[1], rtag[1], ms1[1], ms2[1]);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (r0rdy[1] !== 1'b1 || r1rdy[1] !== 1'b0 || rv[1] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_grant: got rdy0=%b rdy1=%b valid=%b want 1/0/0", r0rdy[1], r1rdy[1], rv[1]);
    end
    @(negedge clk);
    set_req(1, 0, 1'b0, '0, '0, '0);
    set_req(1, 1, 1'b0, '0, '0, '0);
    wait_rsp(1, rc, en, ok);
    checks++;
    if (!ok || rres[1] !== e || rid[1] !== 1'b0 || rtag[1] !== 4'h2) begin
      errors++;
      $display("FAIL rstmid_rsp: got valid=%b result=%h id=%b tag=%h want 1/%h/0/2", rv[1], rres[1], rid[1], rtag[1], e);
    end
    ack_rsp(1);
  endtask

  task automatic test_random(input bit d, input int n_ops);
    logic [31:0] ca[2], cb[2], er;
    logic [3:0]  ct[2], et;
    bit          cv[2], acc[2], ei;
    logic [31:0] q_res[$];
    bit          q_id[$];
    logic [3:0]  q_tag[$];
    int offered, got;
    offered = 0;
    got = 0;
    for (int r = 0; r < 2; r++) begin
      ca[r] = '0; cb[r] = '0; ct[r] = '0; cv[r] = 1'b0; acc[r] = 1'b0;
    end
    for (int c = 0; c < 20000 && got < n_ops; c++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (!cv[r] || acc[r]) begin
          cv[r] = 1'b0;
          if (offered < n_ops && $urandom_range(0, 2) != 0) begin
            ca[r] = $urandom; cb[r] = $urandom; ct[r] = 4'($urandom);
            cv[r] = 1'b1;
            offered++;
          end
          set_req(d, bit'(r), cv[r], ca[r], cb[r], ct[r]);
        end
        acc[r] = 1'b0;
      end
      rr[d] = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if ((r0rdy[d] && r1rdy[d]) || (r0rdy[d] && !cv[0]) || (r1rdy[d] && !cv[1])) begin
        errors++;
        $display("FAIL rand_ready d=%0d: got rdy0=%b rdy1=%b with valid=%b%b want at most one, only if valid",
                 d, r0rdy[d], r1rdy[d], cv[0], cv[1]);
      end
      for (int r = 0; r < 2; r++) begin
        if (cv[r] && get_rdy(d, bit'(r))) begin
          er = ca[r] * cb[r];
          q_res.push_back(er);
          q_id.push_back(bit'(r));
          q_tag.push_back(ct[r]);
          acc[r] = 1'b1;
        end
      end
      if (rv[d] && rr[d]) begin
        got++;
        checks++;
        if (q_res.size() == 0) begin
          errors++;
          $display("FAIL rand_dup d=%0d: got response result=%h with no outstanding op want none", d, rres[d]);
        end else begin
          er = q_res.pop_front();
          ei = q_id.pop_front();
          et = q_tag.pop_front();
          if (rres[d] !== er || rid[d] !== ei || rtag[d] !== et) begin
            errors++;
            $display("FAIL rand_rsp d=%0d op=%0d: got result=%h id=%b tag=%h want %h/%b/%h",
                     d, got, rres[d], rid[d], rtag[d], er, ei, et);
          end
        end
      end
    end
    @(negedge clk);
    rr[d] = 1'b0;
    set_req(d, 1'b0, 1'b0, '0, '0, '0);
    set_req(d, 1'b1, 1'b0, '0, '0, '0);
    checks++;
    if (got != n_ops || q_res.size() != 0) begin
      errors++;
      $display("FAIL rand_count d=%0d: got %0d responses, %0d outstanding want %0d, 0", d, got, q_res.size(), n_ops);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion by time limit want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    test_reset();
    test_single(1'b0, 1'b0, 32'h0001_0003, 32'h0002_0005, 4'h3, 32'h000B_000F);
    test_single(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hA, 32'h0000_0001);
    test_single(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hA, 32'h0000_0001);
    test_single(1'b1, 1'b0, 32'h0001_0003, 32'h0002_0005, 4'h3, 32'h000B_000F);
    test_round_robin(1'b0);
    test_stall();
    test_reset_mid();
    test_random(1'b0, 500);
    test_random(1'b1, 500);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
